datamem_arbiter: RTL and testbench
==================================

Name: datamem_arbiter

Overview:
- Shares the single data memory (combinational read, write on rising clk edge) between two requesters: the CPU load/store port and a debug/loader port.
- The debug/loader port is used for program/data loading and state inspection.
- Sits between the chip datapath (ALU result as address, RD2 as write data, MemWrite) and the data memory.
- Arbitrates round-robin, supports a debug exclusive-lock mode, generates the CPU stall signal and exposes per-port transaction counters.

Parameters:
- AW, 32, address width
- DW, 32, data width
- CW, 16, width of each saturating transaction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU requests an access (level, held until cpu_ack)
- cpu_we  in  1  CPU access is a write
- cpu_addr  in  AW  CPU byte address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  CPU transaction performed this cycle
- cpu_rdata  out  DW  CPU read data, valid while cpu_ack=1
- cpu_stall  out  1  CPU must hold its PC/state this cycle
- dbg_req  in  1  debug requests an access (level, held until dbg_ack)
- dbg_we  in  1  debug access is a write
- dbg_addr  in  AW  debug address
- dbg_wdata  in  DW  debug write data
- dbg_lock  in  1  debug exclusive mode, CPU never granted while high
- dbg_ack  out  1  debug transaction performed this cycle
- dbg_rdata  out  DW  debug read data, valid while dbg_ack=1
- mem_a  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  DW  memory read data (combinational from mem_a)
- cpu_cnt  out  CW  completed CPU transactions, saturating
- dbg_cnt  out  CW  completed debug transactions, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE; last=DBG, so the CPU wins the first tie.
  - cpu_cnt=dbg_cnt=0.
  - All acks 0, mem_we 0, mem_a 0, mem_wd 0.
  - cpu_rdata and dbg_rdata 0.
- States: IDLE, GNT_CPU, GNT_DBG. State, last and the counters are registered. Acks and mem_* are decoded from state (Moore).
- IDLE arbitration, registered at the rising edge:
  - Eligible requesters: cpu_req & ~dbg_lock; dbg_req.
  - None eligible: stay in IDLE.
  - One eligible: go to that requester's GNT state.
  - Both eligible: grant the one not equal to last.
- GNT_X, exactly one cycle:
  - mem_a=X_addr, mem_wd=X_wdata, mem_we=X_we.
  - X_ack=1.
  - X_rdata=mem_rd (pass-through). The write commits at the edge ending the cycle.
  - At that edge: last<=X; X_cnt<=X_cnt+1, saturating at all-ones. Next state is always IDLE.
- Latency and throughput:
  - A request seen in IDLE in cycle n is acked in cycle n+1.
  - Peak throughput is one transaction per 2 cycles.
  - Requests arriving during a GNT cycle are first sampled in the following IDLE.
- Requester rule: after an ack cycle, the requester drops req or presents the next transaction. The arbiter never re-serves within the same GNT cycle.
- Outputs outside a GNT state: mem_we=0, mem_a=0, mem_wd=0, non-granted ack=0, non-granted rdata=0.
- cpu_stall = cpu_req & ~cpu_ack, combinational. Also high whenever cpu_req is high while dbg_lock is high.
- dbg_lock:
  - Sampled only in IDLE.
  - Rising while in GNT_CPU does not abort that transaction.
  - Falling re-enables the CPU at the next IDLE.
- Simultaneous req in IDLE with last=CPU: the debug port wins. Sustained contention alternates strictly CPU, DBG, CPU, ...
- Counter saturation: a counter at 2^CW-1 holds its value. The other counter is unaffected.
- Reset mid-GNT: state immediately IDLE, ack and mem_we drop asynchronously. That transaction's write is not guaranteed; its counter is not incremented.
- No combinational path from req to mem_we. mem_* depend only on registered state and the granted requester's inputs.

Test Plan:
- Reset, then cpu_req=1, we=0, addr=0x10, with mem holding 0xDEADBEEF -> cycle 1 GNT_CPU: cpu_ack=1, cpu_rdata=0xDEADBEEF, mem_we=0; cycle 2 IDLE; cpu_cnt=1; cpu_stall=1 in cycle 0 only.
- Both requesters held with writes (cpu 0x4←0x11, dbg 0x8←0x22) for 8 cycles -> grant order CPU, DBG, CPU, DBG; acks on cycles 1, 3, 5, 7; mem_we only in those cycles; final cpu_cnt=2, dbg_cnt=2.
- dbg_lock=1 with both requesting for 6 cycles -> only dbg_ack pulses (cycles 1, 3, 5); cpu_stall=1 throughout; after dbg_lock=0, the CPU is granted in the next GNT.
- dbg_lock rises during GNT_CPU -> that cpu_ack still completes and the write lands in memory; next grant goes to DBG.
- rst_n low in the middle of GNT_DBG -> dbg_ack and mem_we fall immediately; state IDLE; dbg_cnt unchanged; after release, a first tie goes to the CPU.
- Force dbg_cnt to 0xFFFE, then complete 3 debug transactions -> dbg_cnt reads 0xFFFF, 0xFFFF, 0xFFFF; cpu_cnt unchanged.

Source files
------------

// File: rtl/datamem_arbiter_if.sv
// Bus bundle between the two requesters (CPU load/store port, debug/loader
// port), the data-memory arbiter and the data memory itself.
//
// Handshake: each requester raises X_req together with a stable X_we,
// X_addr and X_wdata and holds all of them until it sees X_ack=1.
// X_ack is a single-cycle pulse. The write commits at the rising edge that
// ends the ack cycle. Read data on X_rdata is valid only while X_ack=1.
// After the ack cycle the requester either drops X_req or presents its
// next transaction. X_req has no combinational path to X_ack or mem_we.
interface datamem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
);
    // CPU load/store port
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    // Debug / program loader port
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_lock;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;

    // Data memory side (combinational read, write on rising clk)
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    // Saturating per-port transaction counters
    logic [CW-1:0] cpu_cnt;
    logic [CW-1:0] dbg_cnt;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_ack, dbg_rdata,
        output mem_a, mem_wd, mem_we,
        input  mem_rd,
        output cpu_cnt, dbg_cnt
    );

    // Requester / memory environment side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_ack, dbg_rdata,
        input  mem_a, mem_wd, mem_we,
        output mem_rd,
        input  cpu_cnt, dbg_cnt
    );
endinterface

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU load/store
// port and the debug/loader port. Every transaction is one IDLE arbitration
// cycle followed by one grant cycle, so peak throughput is one access per
// two cycles. dbg_lock keeps the CPU out entirely while it is high.
// The FSM state is exported on fsm_state for observation.
module datamem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    datamem_arbiter_if.slave        bus,
    output logic [1:0]              fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DBG = 2'd2
    } state_t;

    // Which requester was served most recently (round-robin pointer)
    localparam logic LAST_CPU = 1'b0;
    localparam logic LAST_DBG = 1'b1;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_q;
    state_t        state_d;
    logic          last_q;
    logic [CW-1:0] cpu_cnt_q;
    logic [CW-1:0] dbg_cnt_q;

    logic          cpu_elig;
    logic          dbg_elig;

    // The CPU is only a candidate while debug does not hold the lock
    assign cpu_elig = bus.cpu_req & ~bus.dbg_lock;
    assign dbg_elig = bus.dbg_req;

    // State register: reset lands in IDLE with DBG as last so the CPU wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitrate in IDLE, every grant lasts exactly one cycle
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (cpu_elig && dbg_elig) begin
                    state_d = (last_q == LAST_DBG) ? GNT_CPU : GNT_DBG;
                end else if (cpu_elig) begin
                    state_d = GNT_CPU;
                end else if (dbg_elig) begin
                    state_d = GNT_DBG;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_CPU: state_d = IDLE;
            GNT_DBG: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: memory bus, acks and read data are decoded from state only (Moore)
    always_comb begin
        bus.mem_a     = '0;
        bus.mem_wd    = '0;
        bus.mem_we    = 1'b0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_rdata = '0;
        bus.dbg_ack   = 1'b0;
        bus.dbg_rdata = '0;
        case (state_q)
            GNT_CPU: begin
                bus.mem_a     = bus.cpu_addr;
                bus.mem_wd    = bus.cpu_wdata;
                bus.mem_we    = bus.cpu_we;
                bus.cpu_ack   = 1'b1;
                bus.cpu_rdata = bus.mem_rd;
            end
            GNT_DBG: begin
                bus.mem_a     = bus.dbg_addr;
                bus.mem_wd    = bus.dbg_wdata;
                bus.mem_we    = bus.dbg_we;
                bus.dbg_ack   = 1'b1;
                bus.dbg_rdata = bus.mem_rd;
            end
            default: begin
                bus.mem_a     = '0;
                bus.mem_wd    = '0;
                bus.mem_we    = 1'b0;
                bus.cpu_ack   = 1'b0;
                bus.cpu_rdata = '0;
                bus.dbg_ack   = 1'b0;
                bus.dbg_rdata = '0;
            end
        endcase
    end

    // Round-robin pointer: remember who was served at the edge ending a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LAST_DBG;
        end else if (state_q == GNT_CPU) begin
            last_q <= LAST_CPU;
        end else if (state_q == GNT_DBG) begin
            last_q <= LAST_DBG;
        end
    end

    // CPU transaction counter: counts completed grants, holds at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_cnt_q <= '0;
        end else if ((state_q == GNT_CPU) && (cpu_cnt_q != CNT_MAX)) begin
            cpu_cnt_q <= cpu_cnt_q + 1'b1;
        end
    end

    // Debug transaction counter: counts completed grants, holds at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_cnt_q <= '0;
        end else if ((state_q == GNT_DBG) && (dbg_cnt_q != CNT_MAX)) begin
            dbg_cnt_q <= dbg_cnt_q + 1'b1;
        end
    end

    // The CPU freezes while its access is pending, and always while debug holds the lock
    assign bus.cpu_stall = (bus.cpu_req & ~bus.cpu_ack) | (bus.cpu_req & bus.dbg_lock);

    assign bus.cpu_cnt = cpu_cnt_q;
    assign bus.dbg_cnt = dbg_cnt_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter: reset, single CPU read, round-robin
// contention, debug lock, lock rising during a CPU grant, reset in the
// middle of a debug grant and counter saturation. Inputs change on the
// falling edge; outputs are sampled 1 ns later.
module tb_datamem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GNT_CPU = 2'd1;
    localparam logic [1:0] S_GNT_DBG = 2'd2;

    logic       clk;
    logic       rst_n;
    logic [1:0] fsm_state;

    int n_checks;
    int n_fail;

    // Memory model with a preload path used during reset
    logic [DW-1:0] mem [0:63];
    logic          pre_we;
    logic [5:0]    pre_idx;
    logic [DW-1:0] pre_data;

    datamem_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    datamem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, synchronous write
    assign bus.mem_rd = mem[bus.mem_a[7:2]];
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
        bus.dbg_lock  = 1'b0;
    endtask

    // Returns on the falling edge at which reset is released (cycle 0)
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        clear_inputs();
        pre_we   = 1'b1;
        pre_idx  = 6'd4;
        pre_data = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        pre_we = 1'b0;
        #1;
        n_checks++;
        if (fsm_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, S_IDLE); end
        n_checks++;
        if ({bus.cpu_ack, bus.dbg_ack, bus.mem_we} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b expected 000", {bus.cpu_ack, bus.dbg_ack, bus.mem_we}); end
        n_checks++;
        if ({bus.mem_a, bus.mem_wd} !== 64'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h expected 0", {bus.mem_a, bus.mem_wd}); end
        n_checks++;
        if ({bus.cpu_rdata, bus.dbg_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {bus.cpu_rdata, bus.dbg_rdata}); end
        n_checks++;
        if ({bus.cpu_cnt, bus.dbg_cnt} !== 32'h0) begin n_fail++; $display("FAIL reset_counters: got %h expected 0", {bus.cpu_cnt, bus.dbg_cnt}); end
    endtask

    task automatic test_single_read();
        do_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h10;
        #1;
        n_checks++;
        if ({fsm_state, bus.cpu_ack, bus.cpu_stall} !== {S_IDLE, 1'b0, 1'b1}) begin n_fail++; $display("FAIL read_c0: got state=%0d ack=%b stall=%b expected 0 0 1", fsm_state, bus.cpu_ack, bus.cpu_stall); end
        @(negedge clk); #1;
        n_checks++;
        if ({fsm_state, bus.cpu_ack, bus.cpu_stall, bus.mem_we} !== {S_GNT_CPU, 1'b1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL read_c1_ctrl: got state=%0d ack=%b stall=%b we=%b expected 1 1 0 0", fsm_state, bus.cpu_ack, bus.cpu_stall, bus.mem_we); end
        n_checks++;
        if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_c1_rdata: got %h expected deadbeef", bus.cpu_rdata); end
        n_checks++;
        if (bus.mem_a !== 32'h10) begin n_fail++; $display("FAIL read_c1_addr: got %h expected 10", bus.mem_a); end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        n_checks++;
        if ({fsm_state, bus.cpu_ack, bus.cpu_stall} !== {S_IDLE, 1'b0, 1'b0}) begin n_fail++; $display("FAIL read_c2: got state=%0d ack=%b stall=%b expected 0 0 0", fsm_state, bus.cpu_ack, bus.cpu_stall); end
        n_checks++;
        if (bus.cpu_cnt !== 16'd1) begin n_fail++; $display("FAIL read_cpu_cnt: got %0d expected 1", bus.cpu_cnt); end
        n_checks++;
        if (bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL read_rdata_idle: got %h expected 0", bus.cpu_rdata); end
    endtask

    task automatic test_round_robin();
        logic exp_cpu;
        logic exp_dbg;
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h4; bus.cpu_wdata = 32'h11;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h8; bus.dbg_wdata = 32'h22;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_cpu = (c == 1) || (c == 5);
            exp_dbg = (c == 3) || (c == 7);
            n_checks++;
            if ({bus.cpu_ack, bus.dbg_ack, bus.mem_we} !== {exp_cpu, exp_dbg, exp_cpu | exp_dbg}) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: got cpu_ack=%b dbg_ack=%b mem_we=%b expected %b %b %b", c, bus.cpu_ack, bus.dbg_ack, bus.mem_we, exp_cpu, exp_dbg, exp_cpu | exp_dbg);
            end
            if (exp_dbg) begin
                n_checks++;
                if ({bus.mem_a, bus.mem_wd} !== {32'h8, 32'h22}) begin n_fail++; $display("FAIL rr_dbg_bus%0d: got a=%h wd=%h expected 8 22", c, bus.mem_a, bus.mem_wd); end
            end
        end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        #1;
        n_checks++;
        if ({bus.cpu_cnt, bus.dbg_cnt} !== {16'd2, 16'd2}) begin n_fail++; $display("FAIL rr_counts: got cpu=%0d dbg=%0d expected 2 2", bus.cpu_cnt, bus.dbg_cnt); end
        n_checks++;
        if ({mem[1], mem[2]} !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL rr_mem: got %h %h expected 11 22", mem[1], mem[2]); end
    endtask

    task automatic test_lock();
        do_reset();
        bus.dbg_lock = 1'b1;
        bus.cpu_req  = 1'b1; bus.cpu_addr = 32'h10;
        bus.dbg_req  = 1'b1; bus.dbg_addr = 32'h10;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_checks++;
            if ({bus.cpu_ack, bus.dbg_ack, bus.cpu_stall} !== {1'b0, (c % 2) == 1, 1'b1}) begin
                n_fail++;
                $display("FAIL lock_cycle%0d: got cpu_ack=%b dbg_ack=%b stall=%b expected 0 %b 1", c, bus.cpu_ack, bus.dbg_ack, bus.cpu_stall, (c % 2) == 1);
            end
        end
        n_checks++;
        if (bus.dbg_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lock_dbg_rdata: got %h expected deadbeef", bus.dbg_rdata); end
        @(negedge clk);
        bus.dbg_lock = 1'b0;
        #1;
        n_checks++;
        if (fsm_state !== S_IDLE) begin n_fail++; $display("FAIL unlock_idle: got %0d expected 0", fsm_state); end
        @(negedge clk); #1;
        n_checks++;
        if ({bus.cpu_ack, bus.dbg_ack} !== 2'b10) begin n_fail++; $display("FAIL unlock_cpu_grant: got cpu_ack=%b dbg_ack=%b expected 1 0", bus.cpu_ack, bus.dbg_ack); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_lock_during_cpu();
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'hC;  bus.cpu_wdata = 32'h33;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h14; bus.dbg_wdata = 32'h44;
        @(negedge clk);
        bus.dbg_lock = 1'b1;
        #1;
        n_checks++;
        if ({fsm_state, bus.cpu_ack, bus.mem_we, bus.mem_a} !== {S_GNT_CPU, 1'b1, 1'b1, 32'hC}) begin n_fail++; $display("FAIL lockrise_cpu_ack: got state=%0d ack=%b we=%b a=%h expected 1 1 1 c", fsm_state, bus.cpu_ack, bus.mem_we, bus.mem_a); end
        @(negedge clk); #1;
        n_checks++;
        if (mem[3] !== 32'h33) begin n_fail++; $display("FAIL lockrise_write: got %h expected 33", mem[3]); end
        n_checks++;
        if (bus.cpu_cnt !== 16'd1) begin n_fail++; $display("FAIL lockrise_cpu_cnt: got %0d expected 1", bus.cpu_cnt); end
        @(negedge clk); #1;
        n_checks++;
        if ({bus.cpu_ack, bus.dbg_ack, bus.mem_a} !== {1'b0, 1'b1, 32'h14}) begin n_fail++; $display("FAIL lockrise_next_dbg: got cpu_ack=%b dbg_ack=%b a=%h expected 0 1 14", bus.cpu_ack, bus.dbg_ack, bus.mem_a); end
        @(negedge clk);
        bus.dbg_req = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if ({fsm_state, bus.cpu_ack, bus.cpu_stall} !== {S_IDLE, 1'b0, 1'b1}) begin n_fail++; $display("FAIL lockrise_cpu_blocked: got state=%0d ack=%b stall=%b expected 0 0 1", fsm_state, bus.cpu_ack, bus.cpu_stall); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid_gnt();
        do_reset();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h18; bus.dbg_wdata = 32'h55;
        @(negedge clk); #1;
        n_checks++;
        if ({fsm_state, bus.dbg_ack, bus.mem_we} !== {S_GNT_DBG, 1'b1, 1'b1}) begin n_fail++; $display("FAIL midrst_pre: got state=%0d ack=%b we=%b expected 2 1 1", fsm_state, bus.dbg_ack, bus.mem_we); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({fsm_state, bus.dbg_ack, bus.mem_we} !== {S_IDLE, 1'b0, 1'b0}) begin n_fail++; $display("FAIL midrst_async: got state=%0d ack=%b we=%b expected 0 0 0", fsm_state, bus.dbg_ack, bus.mem_we); end
        n_checks++;
        if (bus.dbg_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_dbg_cnt: got %0d expected 0", bus.dbg_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
        bus.dbg_we  = 1'b0;
        #1;
        n_checks++;
        if (fsm_state !== S_IDLE) begin n_fail++; $display("FAIL midrst_release_idle: got %0d expected 0", fsm_state); end
        @(negedge clk); #1;
        n_checks++;
        if ({bus.cpu_ack, bus.dbg_ack} !== 2'b10) begin n_fail++; $display("FAIL midrst_first_tie: got cpu_ack=%b dbg_ack=%b expected 1 0", bus.cpu_ack, bus.dbg_ack); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        force dut.dbg_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.dbg_cnt_q;
        #1;
        n_checks++;
        if (bus.dbg_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preset: got %h expected fffe", bus.dbg_cnt); end
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h20; bus.dbg_wdata = 32'h66;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 6) bus.dbg_req = 1'b0;
            #1;
            if ((c % 2) == 1) begin
                n_checks++;
                if (bus.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL sat_ack%0d: got %b expected 1", c, bus.dbg_ack); end
            end else begin
                n_checks++;
                if (bus.dbg_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt%0d: got %h expected ffff", c, bus.dbg_cnt); end
            end
        end
        n_checks++;
        if (bus.cpu_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_cpu_cnt: got %0d expected 1", bus.cpu_cnt); end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pre_we   = 1'b0;
        pre_idx  = '0;
        pre_data = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_lock_during_cpu();
        test_reset_mid_gnt();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
